// File: rtl/morse_pkg.sv
// Shared definitions for the Morse character decoder.
//   - Symbol encodings of the 3-bit keying stream (codes 5..7 behave as WAIT)
//   - ASCII space character
//   - Decoder state enumeration
package morse_pkg;

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // IDLE: nothing accumulated; ACCUM: code in progress;
  // FINAL: decoded character is being pushed; PEND_SP: space is being pushed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_FINAL   = 2'd2,
    ST_PEND_SP = 2'd3
  } dec_state_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code lookup (ITU table).
// Parameters:
//   MAX_SYMBOLS  longest accepted code length (4..7); >=5 enables digits
// Ports:
//   len    in   number of symbols in the code
//   code   in   code bits, first symbol in bit len-1, DIT=0, DAH=1
//   hit    out  1 when (len, code) maps to a character
//   ascii  out  decoded character (8'h00 when no hit)
module morse_lut #(
  parameter int MAX_SYMBOLS = 5
) (
  input  logic [$clog2(MAX_SYMBOLS+1)-1:0] len,
  input  logic [MAX_SYMBOLS-1:0]           code,
  output logic                             hit,
  output logic [7:0]                       ascii
);

  // Five code bits are enough to address every table entry; narrower
  // configurations are zero-extended so one table serves all sizes.
  logic [4:0] c5;

  if (MAX_SYMBOLS >= 5) begin : g_wide
    assign c5 = code[4:0];
  end else begin : g_narrow
    assign c5 = {1'b0, code[3:0]};
  end

  always_comb begin
    ascii = 8'h00;
    case (int'(len))
      1: case (c5[0])
           1'b0: ascii = "E";
           1'b1: ascii = "T";
           default: ascii = 8'h00;
         endcase
      2: case (c5[1:0])
           2'b00: ascii = "I";
           2'b01: ascii = "A";
           2'b10: ascii = "N";
           2'b11: ascii = "M";
           default: ascii = 8'h00;
         endcase
      3: case (c5[2:0])
           3'b000: ascii = "S";
           3'b001: ascii = "U";
           3'b010: ascii = "R";
           3'b011: ascii = "W";
           3'b100: ascii = "D";
           3'b101: ascii = "K";
           3'b110: ascii = "G";
           3'b111: ascii = "O";
           default: ascii = 8'h00;
         endcase
      4: case (c5[3:0])
           4'b0000: ascii = "H";
           4'b0001: ascii = "V";
           4'b0010: ascii = "F";
           4'b0100: ascii = "L";
           4'b0110: ascii = "P";
           4'b0111: ascii = "J";
           4'b1000: ascii = "B";
           4'b1001: ascii = "X";
           4'b1010: ascii = "C";
           4'b1011: ascii = "Y";
           4'b1100: ascii = "Z";
           4'b1101: ascii = "Q";
           default: ascii = 8'h00;
         endcase
      5: if (MAX_SYMBOLS >= 5) begin
           case (c5)
             5'b11111: ascii = "0";
             5'b01111: ascii = "1";
             5'b00111: ascii = "2";
             5'b00011: ascii = "3";
             5'b00001: ascii = "4";
             5'b00000: ascii = "5";
             5'b10000: ascii = "6";
             5'b11000: ascii = "7";
             5'b11100: ascii = "8";
             5'b11110: ascii = "9";
             default:  ascii = 8'h00;
           endcase
         end
      default: ascii = 8'h00;
    endcase
    hit = (ascii != 8'h00);
  end

endmodule

// File: rtl/morse_char_decoder.sv
// Morse symbol stream to ASCII decoder with buffered valid/ready output.
// Parameters:
//   MAX_SYMBOLS  longest accepted code length (4..7)
//   OUT_DEPTH    output FIFO entries (power of two, >=2)
//   ERR_CHAR     character emitted for unmapped or overlong codes
//   EMIT_SPACE   1: SPACE emits 8'h20; 0: SPACE behaves as GAP
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_sym       keying symbol (WAIT/DIT/DAH/GAP/SPACE)
//   out_char     character at FIFO head, 8'h00 when empty
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts out_char
//   sym_len      symbols accumulated in the current character
//   err_pulse    high in the cycle ERR_CHAR is written
//   overflow     sticky flag for a dropped push
module morse_char_decoder
  import morse_pkg::*;
#(
  parameter int         MAX_SYMBOLS = 5,
  parameter int         OUT_DEPTH   = 4,
  parameter logic [7:0] ERR_CHAR    = 8'h3F,
  parameter int         EMIT_SPACE  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [2:0]                       in_sym,
  output logic [7:0]                       out_char,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0] sym_len,
  output logic                             err_pulse,
  output logic                             overflow
);

  localparam int LW = $clog2(MAX_SYMBOLS+1);
  localparam int AW = $clog2(OUT_DEPTH);

  dec_state_t             state, state_next;
  logic [MAX_SYMBOLS-1:0] code;
  logic [LW-1:0]          len;
  logic                   too_long;
  logic                   pend_space;
  logic [7:0]             fin_char;
  logic                   fin_err;

  logic       is_mark, is_dah, is_gap, is_space, finalise, len_zero;
  logic       lut_hit;
  logic [7:0] lut_ascii;
  logic       push;
  logic [7:0] push_data;

  logic [7:0] mem [OUT_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, pop, push_ok;

  // Symbol classification; with EMIT_SPACE=0 a SPACE is just a GAP.
  assign is_dah   = (in_sym == SYM_DAH);
  assign is_mark  = (in_sym == SYM_DIT) || is_dah;
  assign is_space = (in_sym == SYM_SPACE) && (EMIT_SPACE != 0);
  assign is_gap   = (in_sym == SYM_GAP) || ((in_sym == SYM_SPACE) && (EMIT_SPACE == 0));
  assign len_zero = (len == '0);
  assign finalise = (is_gap || is_space) && !len_zero;

  morse_lut #(.MAX_SYMBOLS(MAX_SYMBOLS)) u_lut (
    .len   (len),
    .code  (code),
    .hit   (lut_hit),
    .ascii (lut_ascii)
  );

  // Accumulator: an overlong code freezes code/len and only flags too_long,
  // so the character still terminates on the next GAP and decodes as error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code     <= '0;
      len      <= '0;
      too_long <= 1'b0;
    end else if (finalise) begin
      code     <= '0;
      len      <= '0;
      too_long <= 1'b0;
    end else if (is_mark) begin
      if (len == LW'(MAX_SYMBOLS)) begin
        too_long <= 1'b1;
      end else begin
        code <= {code[MAX_SYMBOLS-2:0], is_dah};
        len  <= len + LW'(1);
      end
    end
  end

  // Decoded character is registered so the push happens one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_char <= 8'h00;
      fin_err  <= 1'b0;
    end else if (finalise) begin
      fin_char <= (lut_hit && !too_long) ? lut_ascii : ERR_CHAR;
      fin_err  <= !(lut_hit && !too_long);
    end
  end

  // A SPACE ending a letter defers its own push until after the letter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_space <= 1'b0;
    end else if (finalise && is_space) begin
      pend_space <= 1'b1;
    end else if (state == ST_FINAL) begin
      pend_space <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. FINAL and PEND_SP always hold for a single cycle; a
  // mark arriving in them starts the next character in the same edge.
  always_comb begin
    state_next = ST_IDLE;
    if (finalise) begin
      state_next = ST_FINAL;
    end else if ((is_space && len_zero) || (state == ST_FINAL && pend_space)) begin
      state_next = ST_PEND_SP;
    end else if (is_mark || !len_zero) begin
      state_next = ST_ACCUM;
    end
  end

  // Output logic: push request and error pulse.
  always_comb begin
    push      = 1'b0;
    push_data = fin_char;
    err_pulse = 1'b0;
    case (state)
      ST_FINAL: begin
        push      = 1'b1;
        err_pulse = fin_err;
      end
      ST_PEND_SP: begin
        push      = 1'b1;
        push_data = ASCII_SPACE;
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  // FIFO: extra pointer MSB distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && out_ready;
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && !push_ok) begin
      overflow <= 1'b1;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_char  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign sym_len   = len;

endmodule

// File: tb/tb_morse_char_decoder.sv
// Self-checking bench for morse_char_decoder. Two instances share one
// stimulus stream: one emits spaces, the other treats SPACE as GAP.
module tb_morse_char_decoder;
  import morse_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_sym;
  logic       out_ready;

  logic [7:0] out_char,  out_char_ns;
  logic       out_valid, out_valid_ns;
  logic [2:0] sym_len,   sym_len_ns;
  logic       err_pulse, err_pulse_ns;
  logic       overflow,  overflow_ns;

  int compared   = 0;
  int mismatched = 0;
  int err_cnt    = 0;
  int err_cnt_ns = 0;
  int exp_err    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_ns_q[$];

  morse_char_decoder #(.MAX_SYMBOLS(5), .OUT_DEPTH(4), .ERR_CHAR(8'h3F), .EMIT_SPACE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_sym(in_sym),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .sym_len(sym_len), .err_pulse(err_pulse), .overflow(overflow)
  );

  morse_char_decoder #(.MAX_SYMBOLS(5), .OUT_DEPTH(4), .ERR_CHAR(8'h3F), .EMIT_SPACE(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_sym(in_sym),
    .out_char(out_char_ns), .out_valid(out_valid_ns), .out_ready(out_ready),
    .sym_len(sym_len_ns), .err_pulse(err_pulse_ns), .overflow(overflow_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted character is matched against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_pulse)    err_cnt++;
      if (err_pulse_ns) err_cnt_ns++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) checkOutput("extra_char", exp_q.size(), 1);
        else checkOutput("out_char", out_char, exp_q.pop_front());
      end
      if (out_valid_ns && out_ready) begin
        if (exp_ns_q.size() == 0) checkOutput("extra_char_ns", exp_ns_q.size(), 1);
        else checkOutput("out_char_ns", out_char_ns, exp_ns_q.pop_front());
      end
    end
  end

  // Presents one symbol for exactly one sampling edge, then returns WAIT;
  // returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [2:0] sym);
    in_sym = sym;
    @(posedge clk);
    #1;
    in_sym = SYM_WAIT;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(SYM_WAIT);
  endtask

  // Keys a pattern of '.'/'-' with random WAIT fill, then GAP or SPACE,
  // recording the characters each instance should deliver.
  task automatic sendChar(input string pat, input logic [7:0] exp, input bit endSpace,
                          input bit isErr, input bit expectOut);
    for (int i = 0; i < pat.len(); i++) begin
      applyStimulus((pat[i] == "-") ? SYM_DAH : SYM_DIT);
      repeat ($urandom_range(0, 2)) applyStimulus(3'($urandom_range(5, 7)));
    end
    if (expectOut) begin
      exp_q.push_back(exp);
      exp_ns_q.push_back(exp);
      if (endSpace) exp_q.push_back(ASCII_SPACE);
      if (isErr) exp_err++;
    end
    applyStimulus(endSpace ? SYM_SPACE : SYM_GAP);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_ns_q.size() != 0) && n < 60) begin
      idle(1);
      n++;
    end
    checkOutput({tag, "_q"}, exp_q.size(), 0);
    checkOutput({tag, "_q_ns"}, exp_ns_q.size(), 0);
  endtask

  initial begin
    in_sym    = SYM_WAIT;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst_out_char",  out_char,  0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sym_len",   sym_len,   0);
    checkOutput("rst_err_pulse", err_pulse, 0);
    checkOutput("rst_overflow",  overflow,  0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // A: sym_len steps 1,2,0 and out_valid lasts one cycle.
    applyStimulus(SYM_DIT);
    checkOutput("a_len1", sym_len, 1);
    applyStimulus(SYM_DAH);
    checkOutput("a_len2", sym_len, 2);
    exp_q.push_back("A");
    exp_ns_q.push_back("A");
    applyStimulus(SYM_GAP);
    checkOutput("a_len0", sym_len, 0);
    checkOutput("a_valid_lat", out_valid, 0);
    idle(1);
    checkOutput("a_valid_hi", out_valid, 1);
    checkOutput("a_head", out_char, "A");
    idle(1);
    checkOutput("a_valid_lo", out_valid, 0);
    idle(2);

    // Digits, then a couple of letters.
    sendChar("-----", "0", 0, 0, 1);
    sendChar(".....", "5", 0, 0, 1);
    sendChar("--.-",  "Q", 0, 0, 1);
    sendChar("-..-",  "X", 0, 0, 1);
    waitDrain("dig");
    checkOutput("dig_err", err_cnt, 0);

    // Unmapped and overlong codes.
    sendChar("..--",   8'h3F, 0, 1, 1);
    sendChar("......", 8'h3F, 0, 1, 1);
    waitDrain("err");
    checkOutput("err_cnt",    err_cnt,    exp_err);
    checkOutput("err_cnt_ns", err_cnt_ns, exp_err);

    // T followed by SPACE: letter at +1, space at +2 (space-emitting instance).
    sendChar("-", "T", 1, 0, 1);
    checkOutput("sp_valid0", out_valid, 0);
    idle(1);
    checkOutput("sp_head1", out_char, "T");
    idle(1);
    checkOutput("sp_head2", out_char, ASCII_SPACE);
    checkOutput("sp_ns_empty", out_valid_ns, 0);
    waitDrain("sp");

    // Bare SPACE with nothing accumulated.
    exp_q.push_back(ASCII_SPACE);
    applyStimulus(SYM_SPACE);
    waitDrain("bare_sp");

    // Back-to-back characters with no fill between GAP and next mark.
    sendChar(".-.", "R", 0, 0, 1);
    sendChar("--.", "G", 0, 0, 1);
    waitDrain("b2b");

    // Overflow: consumer stalled, five E characters into a 4-deep FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) sendChar(".", "E", 0, 0, i < 4);
    idle(2);
    checkOutput("ovf_flag",    overflow,    1);
    checkOutput("ovf_flag_ns", overflow_ns, 1);
    checkOutput("ovf_valid",   out_valid,   1);
    checkOutput("ovf_head",    out_char,    "E");
    out_ready = 1'b1;
    waitDrain("ovf");
    checkOutput("ovf_sticky", overflow, 1);
    checkOutput("ovf_empty",  out_valid, 0);

    // Reset in the middle of a character.
    applyStimulus(SYM_DIT);
    applyStimulus(SYM_DAH);
    checkOutput("mid_len", sym_len, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_len", sym_len,  0);
    checkOutput("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    sendChar("-", "T", 0, 0, 1);
    waitDrain("mid");
    checkOutput("mid_ovf_end", overflow, 0);
    idle(3);

    checkOutput("final_err",    err_cnt,    exp_err);
    checkOutput("final_err_ns", err_cnt_ns, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/morse_char_decoder.md
# morse_char_decoder

Parametrised Morse symbol-to-ASCII decoder, next generation of the alphabet FSM. It consumes the same 3-bit dit/dah/gap/space/wait symbol stream from the keying front end. It accumulates an arbitrary-length code and decodes letters, digits and an error character. Decoded characters are delivered through a buffered valid/ready output, so a slow consumer (UART, display) never loses characters silently.

## Interface
- MAX_SYMBOLS, 5: longest accepted code length; legal range 4..7; 5 or more enables digits.
- OUT_DEPTH, 4: output FIFO entries; power of two, at least 2.
- ERR_CHAR, 8'h3F: ASCII emitted for unmapped or overlong codes.
- EMIT_SPACE, 1: 1 emits 8'h20 on SPACE; 0 treats SPACE as GAP.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_sym  in  3  symbol: WAIT=0, DIT=1, DAH=2, GAP=3, SPACE=4; codes 5..7 are treated as WAIT.
- out_char  out  8  ASCII at FIFO head; 8'h00 when empty.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_char when out_valid && out_ready.
- sym_len  out  clog2(MAX_SYMBOLS+1)  symbols accumulated in the current character.
- err_pulse  out  1  one-cycle pulse when ERR_CHAR is pushed.
- overflow  out  1  sticky; set when a push is dropped because the FIFO is full.

## Operation
- Accumulator: shift register code[MAX_SYMBOLS-1:0], counter len, flag too_long.
  - DIT shifts in 0; DAH shifts in 1; the first received symbol ends up MSB of the len-bit code.
  - DIT/DAH with len==MAX_SYMBOLS sets too_long; code and len are unchanged.
- GAP with len>0 finalises the character:
  - Lookup pushes the result; code, len and too_long clear.
  - GAP with len==0 does nothing.
- SPACE with len==0 and EMIT_SPACE=1: push 8'h20.
- SPACE with len>0: finalise the letter, set pend_space, push 8'h20 on the following cycle.
- Lookup covers the standard ITU table:
  - Letters, len 1..4; e.g. A=len2 code 01, Q=len4 code 1101.
  - Digits, len 5, if MAX_SYMBOLS>=5; 0=11111, 1=01111, 5=00000, 9=11110.
  - Any other (len, code) pair, or too_long, gives ERR_CHAR plus err_pulse.
- Decoder states: IDLE (len==0), ACCUM (len>0), FINAL (push cycle), PEND_SP (space push).
  - DIT/DAH received in FINAL or PEND_SP start the next character normally; the accumulator was already cleared.
- FIFO behaviour:
  - Push when not full, or when full with a simultaneous pop.
  - Otherwise the push is dropped and overflow is set; overflow clears only on reset.
  - Simultaneous push and pop on an empty FIFO is not bypassed; the pushed character appears next cycle.

## Timing
- Reset values: out_char=0, out_valid=0, sym_len=0, err_pulse=0, overflow=0, FIFO empty, state IDLE, pend_space=0.
- Reset asserted mid-character discards the partial code and all FIFO contents.
- in_sym is sampled every posedge; WAIT may appear any number of cycles between symbols.
- Latency, from the posedge sampling GAP:
  - Character written at posedge+1.
  - out_valid high from posedge+1 if the FIFO was empty.
- SPACE ending a letter: letter at +1, 8'h20 at +2.
- Pop takes effect at the posedge where out_valid && out_ready; the next head is visible after that edge.
- err_pulse is coincident with the FIFO write of ERR_CHAR, even if the write is dropped; a dropped write also sets overflow.
- Throughput: one push and one pop per cycle.

## Structure
- morse_pkg holds:
  - Symbol localparams SYM_WAIT/DIT/DAH/GAP/SPACE.
  - ASCII_SPACE.
  - The decoder state enum.
- morse_lut is a combinational sub-module: (len, code) -> {hit, ascii}; pure case table.
- The FIFO is inline: pointer-based, OUT_DEPTH entries, with an extra pointer bit for full/empty.
- Top level: accumulator, state register, pend_space, FIFO, flags.

## Test plan
- Key DIT,DAH,GAP with out_ready=1 -> one 8'h41 (A), out_valid high for 1 cycle; sym_len goes 1,2,0.
- Key DAH x5, GAP, then DIT x5, GAP -> 8'h30 then 8'h35; err_pulse never asserted.
- Key DIT,DIT,DAH,DAH,GAP (unmapped) and DIT x6,GAP (overlong) -> two 8'h3F, two err_pulse cycles.
- Key DAH (T), SPACE -> 8'h54 at +1, 8'h20 at +2; with EMIT_SPACE=0 -> only 8'h54.
- out_ready=0; key E,GAP five times with OUT_DEPTH=4 -> 4 entries held, overflow=1; drain -> four 8'h45.
- Key DIT,DAH, assert rst_n low mid-character, release, key DAH,GAP -> only 8'h54 emitted; overflow=0.
